// File: rtl/prog_delay_line.sv
// ---------------------------------------------------------------------------
// prog_delay_line
//
// Multi-channel pipeline delay line whose active delay is chosen at runtime.
// The physical depth is MAX_DELAY stages. Each stage holds one sample for
// every channel plus a shared valid bit. The output is a combinational tap on
// stage (dly_cur-1). After each accepted delay change, a blanking window
// suppresses q_valid. This keeps stale samples, which were aligned for the
// old delay, from being presented as valid.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-low reset
//   en        in   whole-pipeline advance enable
//   in_valid  in   qualifies d
//   d         in   CHANNELS*WIDTH input samples, channel n at [n*WIDTH +: WIDTH]
//   flush     in   clear pipeline contents and blanking counter
//   dly_load  in   strobe requesting a new delay
//   dly_set   in   requested delay (legal range 1..MAX_DELAY)
//   q         out  delayed samples
//   q_valid   out  qualifies q (forced low while busy)
//   dly_cur   out  active delay
//   busy      out  blanking window active
//   dly_err   out  one-cycle pulse after a rejected load request
// ---------------------------------------------------------------------------
module prog_delay_line #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    input  logic                         flush,
    input  logic                         dly_load,
    input  logic [DLY_W-1:0]             dly_set,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic                         q_valid,
    output logic [DLY_W-1:0]             dly_cur,
    output logic                         busy,
    output logic                         dly_err
);

    localparam int                 DW    = CHANNELS * WIDTH;
    localparam logic [DLY_W-1:0]   MAX_D = DLY_W'(MAX_DELAY);

    logic [DW-1:0]        data_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld_q;
    logic [DLY_W-1:0]     dly_cur_q, dly_cur_d;
    logic [DLY_W-1:0]     blank_q, blank_d;
    logic                 err_q, err_d;
    logic                 load_ok;
    logic                 tap_vld;

    // Control next-state logic. dly_load is evaluated independently of
    // flush and en. An accepted load overrides flush's clear of the counter.
    always_comb begin
        load_ok   = dly_load && (dly_set != '0) && (dly_set <= MAX_D);
        dly_cur_d = load_ok ? dly_set : dly_cur_q;
        blank_d   = blank_q;
        if (flush) begin
            blank_d = '0;
        end else if (en && (blank_q != '0)) begin
            blank_d = blank_q - DLY_W'(1);
        end
        if (load_ok) begin
            blank_d = dly_set;
        end
        err_d = dly_load && !load_ok;
    end

    // Sample storage. Flush wins over en, so a flushing edge captures nothing.
    // NOTE: the stage data is reset along with the valids because a
    // freshly reset line must present q=0. This makes it a flop array, not a
    // RAM, which is acceptable at delay-line depths.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (en) begin
            data_q[0] <= d;
            for (int i = 1; i < MAX_DELAY; i++) begin
                data_q[i] <= data_q[i-1];
            end
            vld_q <= {vld_q[MAX_DELAY-2:0], in_valid};
        end
    end

    // Delay setting, blanking counter and error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dly_cur_q <= MAX_D;
            blank_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            dly_cur_q <= dly_cur_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
        end
    end

    // Output tap. This is a compare-select over all stages rather than an
    // indexed read, so an out-of-range dly_cur can never address past the
    // array (it cannot arise, but the mux stays well defined).
    // NOTE: q and tap_vld get defaults before the loop, so no latch is
    // inferred for unmatched delay values.
    always_comb begin
        q       = '0;
        tap_vld = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (dly_cur_q == DLY_W'(i + 1)) begin
                q       = data_q[i];
                tap_vld = vld_q[i];
            end
        end
    end

    assign busy    = (blank_q != '0);
    assign q_valid = tap_vld && !busy;
    assign dly_cur = dly_cur_q;
    assign dly_err = err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// ---------------------------------------------------------------------------
// tb_prog_delay_line
//
// Directed bench for prog_delay_line at default parameters. A reference model
// describes the line as a history of captured samples, newest first. The
// output is the entry dly_cur-1 places back in that history. The model is
// compared against the DUT on every falling edge. Directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_prog_delay_line;

    localparam int WIDTH     = 16;
    localparam int CHANNELS  = 2;
    localparam int MAX_DELAY = 16;
    localparam int DLY_W     = 5;
    localparam int DW        = WIDTH * CHANNELS;

    logic             clk;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic [DW-1:0]    d;
    logic             flush;
    logic             dly_load;
    logic [DLY_W-1:0] dly_set;
    logic [DW-1:0]    q;
    logic             q_valid;
    logic [DLY_W-1:0] dly_cur;
    logic             busy;
    logic             dly_err;

    int total = 0;
    int bad   = 0;

    prog_delay_line #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .MAX_DELAY(MAX_DELAY),
        .DLY_W    (DLY_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_valid(in_valid),
        .d       (d),
        .flush   (flush),
        .dly_load(dly_load),
        .dly_set (dly_set),
        .q       (q),
        .q_valid (q_valid),
        .dly_cur (dly_cur),
        .busy    (busy),
        .dly_err (dly_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic [DW-1:0] s;
    } ent_t;

    ent_t hist[$];      // hist[k] = sample captured k enabled edges ago
    int   m_dly;
    int   m_blank;
    logic m_err;
    bit   m_init = 1'b0;

    always @(posedge clk) begin
        bit ok;
        int nb;
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < MAX_DELAY; i++) hist.push_back('0);
            m_dly   = MAX_DELAY;
            m_blank = 0;
            m_err   = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            ok = dly_load && (int'(dly_set) >= 1) && (int'(dly_set) <= MAX_DELAY);
            nb = m_blank;
            if (flush) begin
                foreach (hist[i]) hist[i] = '0;
                nb = 0;
            end else if (en) begin
                hist.push_front({in_valid, d});
                void'(hist.pop_back());
                if (m_blank > 0) nb = m_blank - 1;
            end
            if (ok) begin
                m_dly = int'(dly_set);
                nb    = int'(dly_set);
            end
            m_blank = nb;
            m_err   = dly_load && !ok;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("model_q",       64'(q),       64'(hist[m_dly-1].s));
            check("model_q_valid", 64'(q_valid), 64'(hist[m_dly-1].v && (m_blank == 0)));
            check("model_dly_cur", 64'(dly_cur), 64'(m_dly));
            check("model_busy",    64'(busy),    64'(m_blank != 0));
            check("model_dly_err", 64'(dly_err), 64'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change on the falling edge and are sampled on the next rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] smp(input int k);
        logic [WIDTH-1:0] c0;
        logic [WIDTH-1:0] c1;
        c0 = WIDTH'(k);
        c1 = WIDTH'(k) ^ 16'hA5A5;
        return {c1, c0};
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; d = '0;
        flush = 1'b0; dly_load = 1'b0; dly_set = '0;
        tick();
        tick();
        check("rst_q",       64'(q),       64'd0);
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_dly_cur", 64'(dly_cur), 64'd16);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_dly_err", 64'(dly_err), 64'd0);
        rst = 1'b1;

        // Ramp at the reset delay of 16, then switch to delay 3 mid-stream.
        en = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            d = smp(k);
            if (k == 20) begin
                dly_load = 1'b1;
                dly_set  = 5'd3;
            end
            tick();
            dly_load = 1'b0;
            if (k == 15) check("ramp_no_valid_yet", 64'(q_valid), 64'd0);
            if (k == 16) begin
                check("ramp_first_valid", 64'(q_valid),          64'd1);
                check("ramp_first_ch0",   64'(q[WIDTH-1:0]),     64'd1);
                check("ramp_first_ch1",   64'(q[DW-1:WIDTH]),    64'(16'h0001 ^ 16'hA5A5));
                check("ramp_dly_cur",     64'(dly_cur),          64'd16);
            end
            if (k >= 20 && k <= 22) begin
                check("blank3_busy",    64'(busy),    64'd1);
                check("blank3_q_valid", 64'(q_valid), 64'd0);
                check("blank3_dly_cur", 64'(dly_cur), 64'd3);
            end
            if (k == 23) begin
                check("blank3_done",   64'(busy),          64'd0);
                check("d3_valid",      64'(q_valid),       64'd1);
                check("d3_ch0",        64'(q[WIDTH-1:0]),  64'd21);
            end
            if (k == 30) check("d3_ch0_late", 64'(q[WIDTH-1:0]), 64'd28);
        end

        // Delay 4, then drain the blanking window with idle enabled cycles.
        in_valid = 1'b0;
        dly_load = 1'b1;
        dly_set  = 5'd4;
        tick();
        dly_load = 1'b0;
        repeat (4) tick();
        check("d4_busy_clear", 64'(busy), 64'd0);

        // en alternates 1,0,1,0. Samples 100,102,... are captured on even i.
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            d  = smp(100 + i);
            tick();
            if (i < 6) begin
                check("en_pat_not_yet", 64'(q_valid), 64'd0);
            end else begin
                check("en_pat_valid", 64'(q_valid),      64'd1);
                check("en_pat_ch0",   64'(q[WIDTH-1:0]), 64'(100 + 2 * (i / 2 - 3)));
            end
        end
        en = 1'b1;
        in_valid = 1'b0;

        // Rejected loads: 0 and 17.
        dly_load = 1'b1;
        dly_set  = 5'd0;
        tick();
        dly_load = 1'b0;
        check("err0_pulse",   64'(dly_err), 64'd1);
        check("err0_dly_cur", 64'(dly_cur), 64'd4);
        check("err0_busy",    64'(busy),    64'd0);
        tick();
        check("err0_clear",   64'(dly_err), 64'd0);
        dly_load = 1'b1;
        dly_set  = 5'd17;
        tick();
        dly_load = 1'b0;
        check("err17_pulse",   64'(dly_err), 64'd1);
        check("err17_dly_cur", 64'(dly_cur), 64'd4);
        tick();
        check("err17_clear",   64'(dly_err), 64'd0);

        // Flush together with en and an accepted load of 2.
        in_valid = 1'b1;
        d        = smp(200);
        flush    = 1'b1;
        dly_load = 1'b1;
        dly_set  = 5'd2;
        tick();
        flush    = 1'b0;
        dly_load = 1'b0;
        check("flush_q_valid", 64'(q_valid), 64'd0);
        check("flush_q",       64'(q),       64'd0);
        check("flush_busy",    64'(busy),    64'd1);
        check("flush_dly_cur", 64'(dly_cur), 64'd2);
        d = smp(201);
        tick();
        check("flush_c1_valid", 64'(q_valid), 64'd0);
        d = smp(202);
        tick();
        check("flush_c2_valid", 64'(q_valid),      64'd1);
        check("flush_c2_ch0",   64'(q[WIDTH-1:0]), 64'd201);

        // Reset in the middle of a blanking window.
        dly_load = 1'b1;
        dly_set  = 5'd5;
        tick();
        dly_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_blank_busy",    64'(busy),    64'd0);
        check("rst_blank_q_valid", 64'(q_valid), 64'd0);
        check("rst_blank_dly_cur", 64'(dly_cur), 64'd16);
        check("rst_blank_q",       64'(q),       64'd0);

        // Freeze the pipeline and tap every stage: all must read zero.
        en = 1'b0;
        in_valid = 1'b0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            dly_load = 1'b1;
            dly_set  = DLY_W'(k);
            tick();
            check("stage_zero", 64'(q),       64'd0);
            check("stage_dly",  64'(dly_cur), 64'(k));
        end
        dly_load = 1'b0;

        // Delay 1: q follows d by one cycle.
        en = 1'b1;
        in_valid = 1'b1;
        dly_load = 1'b1;
        dly_set  = 5'd1;
        d        = smp(299);
        tick();
        dly_load = 1'b0;
        check("d1_busy", 64'(busy), 64'd1);
        d = smp(300);
        tick();
        check("d1_valid", 64'(q_valid), 64'd1);
        check("d1_q",     64'(q),       64'(smp(300)));
        d = smp(301);
        tick();
        check("d1_q_next", 64'(q), 64'(smp(301)));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
